// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
// Also holds the word-alignment helper used for RAM addressing.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/memory_lsu_if.sv
// Core-side request/response handshake of the load/store unit.
// master = memory stage of the core, slave = memory_lsu.
interface memory_lsu_if;
  logic        iREQ_VALID;
  logic        oREQ_READY;
  logic        iREQ_WE;
  logic [1:0]  iREQ_SIZE;
  logic        iREQ_UNSIGNED;
  logic [31:0] iREQ_ADDR;
  logic [31:0] iREQ_WDATA;
  logic        oRSP_VALID;
  logic [31:0] oRSP_RDATA;
  logic        oRSP_ERR;

  modport master (
    output iREQ_VALID, iREQ_WE, iREQ_SIZE, iREQ_UNSIGNED, iREQ_ADDR, iREQ_WDATA,
    input  oREQ_READY, oRSP_VALID, oRSP_RDATA, oRSP_ERR
  );

  modport slave (
    input  iREQ_VALID, iREQ_WE, iREQ_SIZE, iREQ_UNSIGNED, iREQ_ADDR, iREQ_WDATA,
    output oREQ_READY, oRSP_VALID, oRSP_RDATA, oRSP_ERR
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts/extends load data from a RAM word and
// merges sub-word store data into a RAM word. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  function automatic logic [31:0] extend(input logic [15:0] v, input logic is_half,
                                         input logic uns);
    logic signed [15:0] h_s;
    logic signed [7:0]  b_s;
    h_s = signed'(v);
    b_s = signed'(v[7:0]);
    if (is_half) return uns ? {16'h0000, v} : 32'(h_s);
    return uns ? {24'h000000, v[7:0]} : 32'(b_s);
  endfunction

  always_comb begin
    ldata = '0;
    mword = rword;
    case (size)
      SZ_BYTE: begin
        ldata = extend({8'h00, rword[8*lane +: 8]}, 1'b0, is_unsigned);
        mword[8*lane +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata = extend(rword[16*lane[1] +: 16], 1'b1, is_unsigned);
        mword[16*lane[1] +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        ldata = rword;
        mword = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_lsu.sv
// Load/store initiator for the word-addressed RAM responder: sub-word stores
// are read-modify-write, loads are extended, bad requests never touch the RAM.
module memory_lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] RAM_ORIGIN = 32'h100,
  parameter logic [31:0] RAM_LENGTH = 32'h08000
) (
  input  logic              iRAM_CLK,
  input  logic              iRAM_RST,
  memory_lsu_if.slave       req,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [31:0]       oRAM_ADDR,
  output logic [31:0]       oRAM_WDATA,
  input  logic [31:0]       iRAM_RDATA
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  size_e       size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic [31:0] align_rword;
  logic [31:0] ld_data;
  logic [31:0] merged;

  // Window bounds are compared in 33 bits so ORIGIN+LENGTH cannot wrap.
  function automatic logic req_error(input logic [1:0] sz, input logic [31:0] a);
    logic [32:0] a33, lo, hi;
    a33 = {1'b0, a};
    lo  = {1'b0, RAM_ORIGIN};
    hi  = lo + {1'b0, RAM_LENGTH};
    return (sz == SZ_ILL) ||
           ((sz == SZ_HALF) && a[0]) ||
           ((sz == SZ_WORD) && (a[1:0] != 2'b00)) ||
           (a33 < lo) || (a33 >= hi);
  endfunction

  assign accept = req.iREQ_VALID && (state_q == ST_IDLE);

  // In RD the live RAM word is used for load extraction; in WR the captured word.
  assign align_rword = (state_q == ST_RD) ? iRAM_RDATA : word_q;

  lsu_lane_align u_align (
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rword       (align_rword),
    .wdata       (wdata_q),
    .ldata       (ld_data),
    .mword       (merged)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rsp_rdata_d = rsp_rdata_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d      = req.iREQ_ADDR;
          wdata_d     = req.iREQ_WDATA;
          size_d      = size_e'(req.iREQ_SIZE);
          we_d        = req.iREQ_WE;
          uns_d       = req.iREQ_UNSIGNED;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (req_error(req.iREQ_SIZE, req.iREQ_ADDR)) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RSP;
          end else if (!req.iREQ_WE) begin
            state_d = ST_RD;
          end else if (size_e'(req.iREQ_SIZE) == SZ_WORD) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (we_q) begin
          word_d  = iRAM_RDATA;
          state_d = ST_WR;
        end else begin
          rsp_rdata_d = ld_data;
          state_d     = ST_RSP;
        end
      end
      ST_WR:   state_d = ST_RSP;
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
    if (!iRAM_RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_rdata_q <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rsp_rdata_q <= rsp_rdata_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM strobes decode from the state register alone, so an async reset
  // drops WR before the next edge can commit a partial write.
  assign oRAM_CE    = (state_q == ST_RD) || (state_q == ST_WR);
  assign oRAM_RD    = (state_q == ST_RD);
  assign oRAM_WR    = (state_q == ST_WR);
  assign oRAM_ADDR  = oRAM_CE ? word_align(addr_q) : 32'h0;
  assign oRAM_WDATA = oRAM_WR ? merged : 32'h0;

  assign req.oREQ_READY = (state_q == ST_IDLE);
  assign req.oRSP_VALID = (state_q == ST_RSP);
  assign req.oRSP_RDATA = (state_q == ST_RSP) ? rsp_rdata_q : 32'h0;
  assign req.oRSP_ERR   = (state_q == ST_RSP) && rsp_err_q;

endmodule

// File: tb/tb_memory_lsu.sv
// Bench for memory_lsu: RAM responder, byte-level reference memory,
// directed test-plan steps, mid-write reset and randomized traffic.
module tb_memory_lsu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_lsu_if bus();

  logic        ram_ce, ram_rd, ram_wr;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  memory_lsu #(.RAM_ORIGIN(32'h100), .RAM_LENGTH(32'h08000)) dut (
    .iRAM_CLK   (clk),
    .iRAM_RST   (rst),
    .req        (bus),
    .oRAM_CE    (ram_ce),
    .oRAM_RD    (ram_rd),
    .oRAM_WR    (ram_wr),
    .oRAM_ADDR  (ram_addr),
    .oRAM_WDATA (ram_wdata),
    .iRAM_RDATA (ram_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Word-organised RAM responder (what the DUT talks to).
  logic [31:0] ram [0:8191];
  logic [31:0] roff;
  assign roff = ram_addr - 32'h100;

  always_comb begin
    ram_rdata = 32'h0;
    if (ram_ce && ram_rd && (roff < 32'h8000)) ram_rdata = ram[roff[14:2]];
  end

  always @(posedge clk) begin
    if (ram_ce && ram_wr && (roff < 32'h8000)) ram[roff[14:2]] = ram_wdata;
  end

  // Byte-addressed reference memory (what the architecture promises).
  logic [7:0] ref_mem [0:32767];

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || ((sz == 2'b01) && (a % 2 != 0)) ||
           ((sz == 2'b10) && (a % 4 != 0)) || (a < 32'h100) || (a >= 32'h8100);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a);
    longint v;
    int unsigned off;
    off = a - 32'h100;
    v = 0;
    if (sz == 2'b00) begin
      v = ref_mem[off];
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      v = ref_mem[off] + 256 * ref_mem[off + 1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      for (int k = 3; k >= 0; k--) v = v * 256 + ref_mem[off + k];
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    longint v;
    int unsigned base;
    base = a - 32'h100;
    base = base - (base % 4);
    v = 0;
    for (int k = 3; k >= 0; k--) v = v * 256 + ref_mem[base + k];
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned off;
    int n;
    longint v;
    off = a - 32'h100;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = wd;
    for (int k = 0; k < n; k++) begin
      ref_mem[off + k] = 8'(v % 256);
      v = v / 256;
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    int unsigned off;
    off = a - 32'h100;
    ram[off / 4] = w;
    ref_store(2'b10, a, w);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Observations of the last transaction.
  int          r_lat, r_rd, r_wr;
  logic [31:0] r_wr_addr, r_wr_data, r_rdata;
  logic        r_err, r_misalign, r_ce_rsp, r_after, r_accepted;

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    r_lat = 0; r_rd = 0; r_wr = 0;
    r_wr_addr = 32'h0; r_wr_data = 32'h0; r_rdata = 32'hx; r_err = 1'bx;
    r_misalign = 1'b0; r_ce_rsp = 1'b0; r_after = 1'b0; r_accepted = 1'b0;
    @(negedge clk);
    bus.iREQ_VALID = 1'b1; bus.iREQ_WE = we; bus.iREQ_SIZE = sz;
    bus.iREQ_UNSIGNED = uns; bus.iREQ_ADDR = addr; bus.iREQ_WDATA = wd;
    for (int i = 0; i < 20; i++) begin
      if (bus.oREQ_READY) begin
        r_accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (r_accepted) begin
      @(posedge clk);
      #1 bus.iREQ_VALID = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (ram_ce) begin
          if (ram_addr[1:0] != 2'b00) r_misalign = 1'b1;
          if (ram_rd) r_rd++;
          if (ram_wr) begin
            r_wr++;
            r_wr_addr = ram_addr;
            r_wr_data = ram_wdata;
          end
        end
        if (bus.oRSP_VALID) begin
          r_lat = c; r_rdata = bus.oRSP_RDATA; r_err = bus.oRSP_ERR; r_ce_rsp = ram_ce;
          break;
        end
      end
      @(negedge clk);
      r_after = bus.oRSP_VALID;
    end else begin
      bus.iREQ_VALID = 1'b0;
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic        e_err;
    logic [31:0] e_rdata, e_word;
    int          e_lat, e_rd, e_wr;
    e_err = ref_err(sz, addr);
    e_rdata = 32'h0; e_word = 32'h0;
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!we) begin
      e_rdata = ref_load(sz, uns, addr);
      e_lat = 2; e_rd = 1; e_wr = 0;
    end else begin
      ref_store(sz, addr, wd);
      e_word = ref_word(addr);
      e_lat = (sz == 2'b10) ? 2 : 3;
      e_rd  = (sz == 2'b10) ? 0 : 1;
      e_wr  = 1;
    end
    do_req(we, sz, uns, addr, wd);
    check({tag, "_accept"}, 32'(r_accepted), 32'd1);
    check({tag, "_err"}, 32'(r_err), 32'(e_err));
    check({tag, "_rdata"}, r_rdata, e_rdata);
    check({tag, "_lat"}, 32'(r_lat), 32'(e_lat));
    check({tag, "_rdcyc"}, 32'(r_rd), 32'(e_rd));
    check({tag, "_wrcyc"}, 32'(r_wr), 32'(e_wr));
    check({tag, "_align"}, 32'(r_misalign), 32'd0);
    check({tag, "_rspce"}, 32'(r_ce_rsp), 32'd0);
    check({tag, "_onepulse"}, 32'(r_after), 32'd0);
    if (we && !e_err) begin
      check({tag, "_wraddr"}, r_wr_addr, (addr / 4) * 4);
      check({tag, "_wrdata"}, r_wr_data, e_word);
    end
  endtask

  initial begin
    logic [31:0] saved, a;
    logic [1:0]  sz;
    int          pick;

    bus.iREQ_VALID = 1'b0; bus.iREQ_WE = 1'b0; bus.iREQ_SIZE = 2'b00;
    bus.iREQ_UNSIGNED = 1'b0; bus.iREQ_ADDR = 32'h0; bus.iREQ_WDATA = 32'h0;
    for (int i = 0; i < 8192; i++) set_word(32'h100 + 32'(i) * 4, $urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.oREQ_READY), 32'd1);
    check("rst_rspvalid", 32'(bus.oRSP_VALID), 32'd0);
    check("rst_rsperr", 32'(bus.oRSP_ERR), 32'd0);
    check("rst_rsprdata", bus.oRSP_RDATA, 32'h0);
    check("rst_ce", 32'(ram_ce), 32'd0);
    check("rst_rd", 32'(ram_rd), 32'd0);
    check("rst_wr", 32'(ram_wr), 32'd0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_wdata", ram_wdata, 32'h0);
    rst = 1'b1;

    set_word(32'h100, 32'h8877_66F5);
    txn("ldb101s", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    check("ldb101s_const", r_rdata, 32'h0000_0066);
    txn("ldb100s", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    check("ldb100s_const", r_rdata, 32'hFFFF_FFF5);
    txn("ldb100u", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
    check("ldb100u_const", r_rdata, 32'h0000_00F5);
    txn("ldh102s", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    check("ldh102s_const", r_rdata, 32'hFFFF_8877);
    txn("ldh102u", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    check("ldh102u_const", r_rdata, 32'h0000_8877);

    txn("stw104", 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF);
    check("stw104_addr_const", r_wr_addr, 32'h104);
    txn("ldw104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    check("ldw104_const", r_rdata, 32'hDEAD_BEEF);
    txn("stb106", 1'b1, 2'b00, 1'b0, 32'h106, 32'h0000_00AB);
    check("stb106_wdata_const", r_wr_data, 32'hDEAB_BEEF);
    txn("ldw104b", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    check("ldw104b_const", r_rdata, 32'hDEAB_BEEF);

    txn("errw102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    txn("errh101", 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234);
    txn("errsz3",  1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    txn("errb0ff", 1'b0, 2'b00, 1'b0, 32'h0FF, 32'h0);
    txn("errb8100", 1'b1, 2'b00, 1'b0, 32'h8100, 32'h55);
    check("err_const", 32'(r_err), 32'd1);
    txn("lastb80ff", 1'b0, 2'b00, 1'b1, 32'h80FF, 32'h0);

    // Reset during the WR cycle of a sub-word store.
    saved = ref_word(32'h10C);
    @(negedge clk);
    bus.iREQ_VALID = 1'b1; bus.iREQ_WE = 1'b1; bus.iREQ_SIZE = 2'b00;
    bus.iREQ_UNSIGNED = 1'b0; bus.iREQ_ADDR = 32'h10D; bus.iREQ_WDATA = 32'h5A;
    check("mid_ready", 32'(bus.oREQ_READY), 32'd1);
    @(posedge clk);
    #1 bus.iREQ_VALID = 1'b0;
    @(negedge clk);
    check("mid_rdphase", 32'(ram_rd), 32'd1);
    @(negedge clk);
    check("mid_wrphase", 32'(ram_wr), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_wr_drop", 32'(ram_wr), 32'd0);
    check("mid_ce_drop", 32'(ram_ce), 32'd0);
    @(posedge clk);
    #1;
    check("mid_mem_unchanged", ram[3], saved);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_ready_after", 32'(bus.oREQ_READY), 32'd1);
    check("mid_rspvalid_after", 32'(bus.oRSP_VALID), 32'd0);
    txn("mid_readback", 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0);

    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0) a = 32'($urandom_range(0, 255));
      else if (pick == 1) a = 32'h8100 + 32'($urandom_range(0, 255));
      else a = 32'h100 + 32'($urandom_range(0, 32'h7FFF));
      pick = $urandom_range(0, 7);
      sz = (pick == 7) ? 2'b11 : 2'(pick % 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = (a / 2) * 2;
        if (sz == 2'b10) a = (a / 4) * 4;
      end
      txn("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
